// File: rtl/sprite_motion_engine.sv
// Sprite motion engine: per-sprite position/speed/direction, one sprite advanced per clock after each frame pulse.
// Latency: sprite i is updated at the (i+1)th edge after next_frame is sampled; bounce pulses the following cycle.
// Backpressure: none; next_frame while a sweep is running is dropped and latches o_overrun. Optional macro: WRAP_MODE_EN.
module sprite_motion_engine #(
  parameter int NUM_SPRITES   = 4,
  parameter int COORD_W       = 8,
  parameter int SPEED_W       = 2,
  parameter int SPRITE_WIDTH  = 12,
  parameter int SPRITE_HEIGHT = 14,
  parameter int WIDTH_SMALL   = 160,
  parameter int HEIGHT_SMALL  = 120
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_enable_movement,
  input  logic                           i_next_frame,
  input  logic                           i_cfg_shift,
  input  logic                           i_cfg_data,
  input  logic                           i_cfg_load,
  output logic [NUM_SPRITES*COORD_W-1:0] o_sprite_x,
  output logic [NUM_SPRITES*COORD_W-1:0] o_sprite_y,
  output logic [NUM_SPRITES-1:0]         o_bounce,
  output logic                           o_busy,
  output logic                           o_overrun
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CFG_W = IDX_W + 2*COORD_W + 2*SPEED_W + 3;

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(WIDTH_SMALL - SPRITE_WIDTH);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(HEIGHT_SMALL - SPRITE_HEIGHT);

  // Bit offsets of the config word fields, LSB upward: wrap, dir_y, dir_x, speed_y, speed_x, y, x, idx
  localparam int OFS_WRAP = 0;
  localparam int OFS_DY   = 1;
  localparam int OFS_DX   = 2;
  localparam int OFS_SY   = 3;
  localparam int OFS_SX   = OFS_SY + SPEED_W;
  localparam int OFS_Y    = OFS_SX + SPEED_W;
  localparam int OFS_X    = OFS_Y + COORD_W;
  localparam int OFS_IDX  = OFS_X + COORD_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_busy;
  logic               r_overrun;
  logic [CFG_W-1:0]   r_sr;

  logic [COORD_W-1:0] r_x  [NUM_SPRITES];
  logic [COORD_W-1:0] r_y  [NUM_SPRITES];
  logic [SPEED_W-1:0] r_sx [NUM_SPRITES];
  logic [SPEED_W-1:0] r_sy [NUM_SPRITES];
  logic               r_dx [NUM_SPRITES];
  logic               r_dy [NUM_SPRITES];
`ifdef WRAP_MODE_EN
  logic               r_wrap [NUM_SPRITES];
`endif
  logic [NUM_SPRITES-1:0] r_bounce;

  // One axis step: returns {bounced_or_wrapped, new_dir, new_pos}.
  // Arithmetic is one bit wider than the coordinate so pos+speed never overflows.
  function automatic logic [COORD_W+1:0] f_step(
    input logic [COORD_W-1:0] pos,
    input logic [SPEED_W-1:0] spd,
    input logic               dir,
    input logic               wrap_en,
    input logic [COORD_W-1:0] lim
  );
    logic [COORD_W:0]   w_p;
    logic [COORD_W:0]   w_s;
    logic [COORD_W:0]   w_m;
    logic [COORD_W:0]   w_sum;
    logic [COORD_W-1:0] w_np;
    logic               w_nd;
    logic               w_b;
    w_p   = {1'b0, pos};
    w_s   = (COORD_W+1)'(spd);
    w_m   = {1'b0, lim};
    w_sum = w_p + w_s;
    w_np  = pos;
    w_nd  = dir;
    w_b   = 1'b0;
    if (spd != '0) begin
      if (!dir) begin
        if (wrap_en) begin
          if (w_sum > w_m) begin
            w_np = COORD_W'(w_sum - w_m - (COORD_W+1)'(1));
            w_b  = 1'b1;
          end else begin
            w_np = COORD_W'(w_sum);
          end
        end else if (w_sum >= w_m) begin
          w_np = lim;
          w_nd = 1'b1;
          w_b  = 1'b1;
        end else begin
          w_np = COORD_W'(w_sum);
        end
      end else begin
        if (wrap_en) begin
          if (w_p < w_s) begin
            w_np = COORD_W'(w_p + w_m + (COORD_W+1)'(1) - w_s);
            w_b  = 1'b1;
          end else begin
            w_np = COORD_W'(w_p - w_s);
          end
        end else if (w_p <= w_s) begin
          w_np = '0;
          w_nd = 1'b0;
          w_b  = 1'b1;
        end else begin
          w_np = COORD_W'(w_p - w_s);
        end
      end
    end
    return {w_b, w_nd, w_np};
  endfunction

  // Config word decode straight off the shift register
  logic [IDX_W-1:0]   w_cfg_idx;
  logic [COORD_W-1:0] w_cfg_x;
  logic [COORD_W-1:0] w_cfg_y;
  logic [COORD_W-1:0] w_cfg_x_clamp;
  logic [COORD_W-1:0] w_cfg_y_clamp;
  logic [SPEED_W-1:0] w_cfg_sx;
  logic [SPEED_W-1:0] w_cfg_sy;
  logic               w_cfg_dx;
  logic               w_cfg_dy;
  logic               w_load_ok;

  assign w_cfg_idx     = r_sr[OFS_IDX +: IDX_W];
  assign w_cfg_x       = r_sr[OFS_X +: COORD_W];
  assign w_cfg_y       = r_sr[OFS_Y +: COORD_W];
  assign w_cfg_sx      = r_sr[OFS_SX +: SPEED_W];
  assign w_cfg_sy      = r_sr[OFS_SY +: SPEED_W];
  assign w_cfg_dx      = r_sr[OFS_DX];
  assign w_cfg_dy      = r_sr[OFS_DY];
  assign w_cfg_x_clamp = (w_cfg_x > MAX_X) ? MAX_X : w_cfg_x;
  assign w_cfg_y_clamp = (w_cfg_y > MAX_Y) ? MAX_Y : w_cfg_y;
  // Out-of-range sprite indices make the load a no-op
  assign w_load_ok     = i_cfg_load && ({1'b0, w_cfg_idx} < (IDX_W+1)'(NUM_SPRITES));

  // Single shared step unit, fed by the sprite under the sweep pointer
  logic               w_upd;
  logic               w_wrap_sel;
  logic [COORD_W+1:0] w_step_x;
  logic [COORD_W+1:0] w_step_y;

  assign w_upd = (r_state == S_RUN);
`ifdef WRAP_MODE_EN
  assign w_wrap_sel = r_wrap[r_ptr];
`else
  assign w_wrap_sel = 1'b0;
`endif
  assign w_step_x = f_step(r_x[r_ptr], r_sx[r_ptr], r_dx[r_ptr], w_wrap_sel, MAX_X);
  assign w_step_y = f_step(r_y[r_ptr], r_sy[r_ptr], r_dy[r_ptr], w_wrap_sel, MAX_Y);

  // Serial config shift register; a load in the same cycle freezes it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sr <= '0;
    end else if (!i_cfg_load && i_cfg_shift) begin
      r_sr <= {r_sr[CFG_W-2:0], i_cfg_data};
    end
  end

  // Sweep FSM: walks the pointer across all sprites once per accepted frame pulse
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_next_frame && i_enable_movement) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_next_frame) begin
            r_overrun <= 1'b1;
          end
          if (r_ptr == IDX_W'(NUM_SPRITES - 1)) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sprite state: a config load beats the sweep step for the same sprite
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_x[i]  <= '0;
        r_y[i]  <= '0;
        r_sx[i] <= SPEED_W'(1);
        r_sy[i] <= SPEED_W'(1);
        r_dx[i] <= 1'b0;
        r_dy[i] <= 1'b0;
`ifdef WRAP_MODE_EN
        r_wrap[i] <= 1'b0;
`endif
      end
      r_bounce <= '0;
    end else begin
      r_bounce <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_load_ok && (w_cfg_idx == IDX_W'(i))) begin
          r_x[i]  <= w_cfg_x_clamp;
          r_y[i]  <= w_cfg_y_clamp;
          r_sx[i] <= w_cfg_sx;
          r_sy[i] <= w_cfg_sy;
          r_dx[i] <= w_cfg_dx;
          r_dy[i] <= w_cfg_dy;
`ifdef WRAP_MODE_EN
          r_wrap[i] <= r_sr[OFS_WRAP];
`endif
        end else if (w_upd && (r_ptr == IDX_W'(i))) begin
          r_x[i]      <= w_step_x[COORD_W-1:0];
          r_dx[i]     <= w_step_x[COORD_W];
          r_y[i]      <= w_step_y[COORD_W-1:0];
          r_dy[i]     <= w_step_y[COORD_W];
          r_bounce[i] <= w_step_x[COORD_W+1] | w_step_y[COORD_W+1];
        end
      end
    end
  end

  // Pack per-sprite coordinates onto the flat output buses
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign o_sprite_x[g*COORD_W +: COORD_W] = r_x[g];
    assign o_sprite_y[g*COORD_W +: COORD_W] = r_y[g];
  end

  assign o_bounce  = r_bounce;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule
